// File: rtl/cmd_rx_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module  : cmd_rx_pkg                                                  |
// | Purpose : Shared constants for the command receiver: register map     |
// |           offsets, capture state encoding and status bit positions.   |
// | Ports   : none (package)                                              |
// | Rev     : 1.0 - initial release                                       |
// +-----------------------------------------------------------------------+
package cmd_rx_pkg;

   // Register map (byte offsets relative to the IP base)
   localparam int unsigned REG_VERSION = 0;
   localparam int unsigned REG_STATUS  = 1;
   localparam int unsigned REG_LEN     = 2;   // 2 = low byte, 3 = high byte
   localparam int unsigned REG_CNT     = 4;   // 4 = low byte, 5 = high byte
   localparam int unsigned REG_CONF    = 6;
   localparam int unsigned MEM_OFFSET  = 16;

   // Capture state encoding
   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_ARMED   = 2'd1;
   localparam logic [1:0] ST_CAPTURE = 2'd2;
   localparam logic [1:0] ST_DONE    = 2'd3;

   // Status register bit positions
   localparam int unsigned STAT_BUSY     = 0;
   localparam int unsigned STAT_DONE     = 1;
   localparam int unsigned STAT_OVERFLOW = 2;

   // Configuration register bit positions
   localparam int unsigned CONF_EXT_START = 0;

endpackage
`default_nettype wire

// File: rtl/cmd_rx_mem.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module  : cmd_rx_mem                                                  |
// | Purpose : Simple dual-port byte RAM. One synchronous write port fed   |
// |           by the capture logic, one registered read port for the bus. |
// | Ports   : clk_i            clock                                      |
// |           we_i/waddr_i/wdata_i   write port                           |
// |           re_i/raddr_i           read request                         |
// |           rdata_o          read data, updated only when re_i is high  |
// | Rev     : 1.0 - initial release                                       |
// +-----------------------------------------------------------------------+
module cmd_rx_mem #(
   parameter int unsigned DEPTH = 2048,
   parameter int unsigned AW    = $clog2(DEPTH)
) (
   input  logic          clk_i,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [7:0]    wdata_i,
   input  logic          re_i,
   input  logic [AW-1:0] raddr_i,
   output logic [7:0]    rdata_o
);

   logic [7:0] mem_q [DEPTH];
   logic [7:0] rdata_q;

   // No reset on the array or the output register so the RAM maps onto
   // block RAM primitives.
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (re_i) begin
         rdata_q <= mem_q[raddr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/cmd_rx_core.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module  : cmd_rx_core                                                 |
// | Purpose : Deserializes the sequencer command stream (bit + strobe +   |
// |           start flag) into bytes, stores them in a capture memory and |
// |           exposes control/status/memory over the basil register bus.  |
// | Ports   : BUS_CLK, BUS_RST_N (async, active low)                      |
// |           BUS_ADD/BUS_DATA_IN/BUS_RD/BUS_WR  register bus inputs      |
// |           BUS_DATA_OUT     registered read data                       |
// |           CMD_DATA/CMD_BIT_EN/CMD_START_FLAG  serial command stream   |
// |           RX_BUSY (armed or capturing), RX_DONE (capture finished)    |
// | Rev     : 1.0 - initial release                                       |
// +-----------------------------------------------------------------------+
module cmd_rx_core
   import cmd_rx_pkg::*;
#(
   parameter int unsigned ABUSWIDTH = 16,
   parameter int unsigned MEM_SIZE  = 2048,
   parameter int unsigned VERSION   = 1
) (
   input  logic                 BUS_CLK,
   input  logic                 BUS_RST_N,
   input  logic [ABUSWIDTH-1:0] BUS_ADD,
   input  logic [7:0]           BUS_DATA_IN,
   input  logic                 BUS_RD,
   input  logic                 BUS_WR,
   output logic [7:0]           BUS_DATA_OUT,
   input  logic                 CMD_DATA,
   input  logic                 CMD_BIT_EN,
   input  logic                 CMD_START_FLAG,
   output logic                 RX_BUSY,
   output logic                 RX_DONE
);

   localparam int unsigned AW      = $clog2(MEM_SIZE);
   // 17 bits: an 8 KiB memory holds 65536 bits, one more than 16 bits can count.
   localparam logic [16:0] MEMBITS = 17'(MEM_SIZE * 8);

   logic [1:0]  state_q, state_d;
   logic [16:0] cnt_q,   cnt_d;
   logic [7:0]  shift_q, shift_d;
   logic        ovf_q,   ovf_d;
   logic [15:0] len_q,   len_d;
   logic [7:0]  conf_q,  conf_d;
   logic [7:0]  rdata_q, rdata_d;
   logic        sel_mem_q, sel_mem_d;

   logic [31:0] w_add32;
   logic        w_is_mem;
   logic        w_soft_rst;
   logic        w_arm;
   logic        w_len_over;
   logic [16:0] w_len_eff;
   logic        w_take;
   logic [7:0]  w_shift;
   logic [16:0] w_cnt_inc;
   logic        w_last;
   logic [2:0]  w_fill;
   logic [2:0]  w_pad;
   logic        w_mem_we;
   logic [7:0]  w_mem_wdata;
   logic [AW-1:0] w_mem_waddr;
   logic [AW-1:0] w_mem_raddr;
   logic [7:0]  w_mem_rdata;
   logic [7:0]  w_reg_rdata;
   logic [7:0]  w_status;

   // ---------------- bus decode ----------------
   assign w_add32     = 32'(BUS_ADD);
   assign w_is_mem    = (w_add32 >= MEM_OFFSET) && (w_add32 < MEM_OFFSET + MEM_SIZE);
   assign w_soft_rst  = BUS_WR && (w_add32 == REG_VERSION);
   assign w_arm       = BUS_WR && (w_add32 == REG_STATUS) && BUS_DATA_IN[0];
   assign w_mem_raddr = AW'(w_add32 - MEM_OFFSET);

   // ---------------- capture datapath ----------------
   // Lengths beyond the memory are clipped; 0 selects the full memory.
   assign w_len_over = {1'b0, len_q} > MEMBITS;
   assign w_len_eff  = ((len_q == 16'd0) || w_len_over) ? MEMBITS : {1'b0, len_q};

   assign w_take = CMD_BIT_EN &&
                   ((state_q == ST_CAPTURE) ||
                    ((state_q == ST_ARMED) && (!conf_q[CONF_EXT_START] || CMD_START_FLAG)));

   assign w_shift   = {shift_q[6:0], CMD_DATA};
   assign w_cnt_inc = cnt_q + 17'd1;
   // >= rather than == so a length lowered mid-capture still terminates.
   assign w_last    = w_cnt_inc >= w_len_eff;
   assign w_fill    = w_cnt_inc[2:0];
   // Left-align a partial final byte; a full byte (fill 0) needs no shift.
   assign w_pad     = 3'(4'd8 - {1'b0, w_fill});

   assign w_mem_we    = w_take && !w_soft_rst && ((w_fill == 3'd0) || w_last);
   assign w_mem_wdata = w_shift << w_pad;
   assign w_mem_waddr = cnt_q[AW+2:3];

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      shift_d = shift_q;
      ovf_d   = ovf_q;
      len_d   = len_q;
      conf_d  = conf_q;

      if (w_soft_rst) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
         shift_d = '0;
         ovf_d   = 1'b0;
      end else if (w_arm && ((state_q == ST_IDLE) || (state_q == ST_DONE))) begin
         state_d = ST_ARMED;
         cnt_d   = '0;
         shift_d = '0;
         ovf_d   = 1'b0;
      end else if (w_take) begin
         shift_d = w_shift;
         cnt_d   = w_cnt_inc;
         if (w_last) begin
            state_d = ST_DONE;
            ovf_d   = w_len_over;
         end else begin
            state_d = ST_CAPTURE;
         end
      end

      if (BUS_WR) begin
         if (w_add32 == REG_LEN)     len_d[7:0]  = BUS_DATA_IN;
         if (w_add32 == REG_LEN + 1) len_d[15:8] = BUS_DATA_IN;
         if (w_add32 == REG_CONF)    conf_d      = BUS_DATA_IN;
      end
   end

   // ---------------- register read path ----------------
   always_comb begin
      w_status                = '0;
      w_status[STAT_BUSY]     = (state_q == ST_ARMED) || (state_q == ST_CAPTURE);
      w_status[STAT_DONE]     = (state_q == ST_DONE);
      w_status[STAT_OVERFLOW] = ovf_q;
   end

   always_comb begin
      w_reg_rdata = '0;
      case (w_add32)
         REG_VERSION: w_reg_rdata = 8'(VERSION);
         REG_STATUS:  w_reg_rdata = w_status;
         REG_LEN:     w_reg_rdata = len_q[7:0];
         REG_LEN + 1: w_reg_rdata = len_q[15:8];
         REG_CNT:     w_reg_rdata = cnt_q[7:0];
         REG_CNT + 1: w_reg_rdata = cnt_q[15:8];
         REG_CONF:    w_reg_rdata = conf_q;
         default:     w_reg_rdata = '0;
      endcase
   end

   // Both the register data and the mux select only move on a read, so the
   // output holds its value until the next BUS_RD.
   always_comb begin
      rdata_d   = rdata_q;
      sel_mem_d = sel_mem_q;
      if (BUS_RD) begin
         rdata_d   = w_reg_rdata;
         sel_mem_d = w_is_mem;
      end
   end

   always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
      if (!BUS_RST_N) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         shift_q   <= '0;
         ovf_q     <= 1'b0;
         len_q     <= '0;
         conf_q    <= '0;
         rdata_q   <= '0;
         sel_mem_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         shift_q   <= shift_d;
         ovf_q     <= ovf_d;
         len_q     <= len_d;
         conf_q    <= conf_d;
         rdata_q   <= rdata_d;
         sel_mem_q <= sel_mem_d;
      end
   end

   cmd_rx_mem #(
      .DEPTH (MEM_SIZE),
      .AW    (AW)
   ) u_mem (
      .clk_i   (BUS_CLK),
      .we_i    (w_mem_we),
      .waddr_i (w_mem_waddr),
      .wdata_i (w_mem_wdata),
      .re_i    (BUS_RD && w_is_mem),
      .raddr_i (w_mem_raddr),
      .rdata_o (w_mem_rdata)
   );

   assign BUS_DATA_OUT = sel_mem_q ? w_mem_rdata : rdata_q;
   assign RX_BUSY      = w_status[STAT_BUSY];
   assign RX_DONE      = w_status[STAT_DONE];

endmodule
`default_nettype wire

// File: tb/tb_cmd_rx_core.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module  : tb_cmd_rx_core                                              |
// | Purpose : Self-checking bench for cmd_rx_core (MEM_SIZE=16) against a |
// |           bit-list reference model of the capture behaviour.          |
// | Rev     : 1.0 - initial release                                       |
// +-----------------------------------------------------------------------+
module tb_cmd_rx_core;

   localparam int MEM_SIZE = 16;
   localparam int MEMBITS  = MEM_SIZE * 8;

   logic        BUS_CLK = 1'b0;
   logic        BUS_RST_N = 1'b0;
   logic [15:0] BUS_ADD = '0;
   logic [7:0]  BUS_DATA_IN = '0;
   logic        BUS_RD = 1'b0;
   logic        BUS_WR = 1'b0;
   logic [7:0]  BUS_DATA_OUT;
   logic        CMD_DATA = 1'b0;
   logic        CMD_BIT_EN = 1'b0;
   logic        CMD_START_FLAG = 1'b0;
   logic        RX_BUSY;
   logic        RX_DONE;

   int errors = 0;
   int checks = 0;

   always #5 BUS_CLK = ~BUS_CLK;

   cmd_rx_core #(
      .ABUSWIDTH (16),
      .MEM_SIZE  (MEM_SIZE),
      .VERSION   (1)
   ) dut (
      .BUS_CLK        (BUS_CLK),
      .BUS_RST_N      (BUS_RST_N),
      .BUS_ADD        (BUS_ADD),
      .BUS_DATA_IN    (BUS_DATA_IN),
      .BUS_RD         (BUS_RD),
      .BUS_WR         (BUS_WR),
      .BUS_DATA_OUT   (BUS_DATA_OUT),
      .CMD_DATA       (CMD_DATA),
      .CMD_BIT_EN     (CMD_BIT_EN),
      .CMD_START_FLAG (CMD_START_FLAG),
      .RX_BUSY        (RX_BUSY),
      .RX_DONE        (RX_DONE)
   );

   // ---------------- reference model ----------------
   bit       m_armed, m_capt, m_done, m_ovf;
   bit       m_bits[$];
   int       m_len, m_conf;
   bit [7:0] m_mem   [MEM_SIZE];
   bit       m_valid [MEM_SIZE];

   function automatic bit [7:0] model_byte(input int idx);
      bit [7:0] v = '0;
      for (int k = 0; k < 8; k++) begin
         int p = idx * 8 + k;
         v = {v[6:0], (p < m_bits.size()) ? m_bits[p] : 1'b0};
      end
      return v;
   endfunction

   task automatic model_store(input int idx);
      m_mem[idx]   = model_byte(idx);
      m_valid[idx] = 1'b1;
   endtask

   task automatic model_arm();
      if (!(m_armed || m_capt)) begin
         m_armed = 1; m_done = 0; m_ovf = 0;
         m_bits.delete();
      end
   endtask

   task automatic model_soft_reset();
      m_armed = 0; m_capt = 0; m_done = 0; m_ovf = 0;
      m_bits.delete();
   endtask

   task automatic model_bit(input bit d, input bit f);
      int n, eff;
      if (m_armed && (!m_conf[0] || f)) begin
         m_armed = 0; m_capt = 1;
      end
      if (m_capt) begin
         m_bits.push_back(d);
         n   = m_bits.size();
         eff = (m_len == 0 || m_len > MEMBITS) ? MEMBITS : m_len;
         if (n % 8 == 0) model_store((n - 1) / 8);
         if (n >= eff) begin
            m_capt = 0; m_done = 1; m_ovf = (m_len > MEMBITS);
            if (n % 8 != 0) model_store((n - 1) / 8);
         end
      end
   endtask

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // ---------------- bus / stream drivers ----------------
   task automatic tick();
      @(posedge BUS_CLK); #1;
   endtask

   task automatic bus_write(input int addr, input logic [7:0] d);
      BUS_ADD = 16'(addr); BUS_DATA_IN = d; BUS_WR = 1'b1;
      tick();
      BUS_WR = 1'b0;
   endtask

   task automatic bus_read(input int addr, output logic [7:0] d);
      BUS_ADD = 16'(addr); BUS_RD = 1'b1;
      tick();
      BUS_RD = 1'b0;
      d = BUS_DATA_OUT;
   endtask

   task automatic do_arm();
      bus_write(1, 8'h01); model_arm();
   endtask

   task automatic set_len(input int v);
      bus_write(2, 8'(v)); bus_write(3, 8'(v >> 8)); m_len = v;
   endtask

   task automatic set_conf(input int v);
      bus_write(6, 8'(v)); m_conf = v;
   endtask

   task automatic send_bit(input bit d, input bit f, input int gap);
      CMD_DATA = d; CMD_START_FLAG = f; CMD_BIT_EN = 1'b1;
      tick();
      CMD_BIT_EN = 1'b0; CMD_START_FLAG = 1'b0;
      model_bit(d, f);
      repeat (gap) tick();
   endtask

   task automatic send_byte(input logic [7:0] b, input bit flag_first, input int gap);
      for (int i = 7; i >= 0; i--) send_bit(b[i], (i == 7) && flag_first, gap);
   endtask

   task automatic check_all(input string tag);
      logic [7:0] d;
      int cnt = m_bits.size();
      bus_read(1, d);
      check({tag, ".status"}, d, {29'd0, m_ovf, m_done, m_armed || m_capt});
      bus_read(4, d); check({tag, ".cnt_lo"}, d, cnt & 8'hFF);
      bus_read(5, d); check({tag, ".cnt_hi"}, d, (cnt >> 8) & 8'hFF);
      check({tag, ".rx_busy"}, RX_BUSY, m_armed || m_capt);
      check({tag, ".rx_done"}, RX_DONE, m_done);
      for (int i = 0; i < MEM_SIZE; i++) begin
         if (m_valid[i]) begin
            bus_read(16 + i, d);
            check($sformatf("%s.mem%0d", tag, i), d, m_mem[i]);
         end
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [7:0] d;
      for (int i = 0; i < MEM_SIZE; i++) m_valid[i] = 0;
      m_len = 0; m_conf = 0;
      model_soft_reset();

      #12 BUS_RST_N = 1'b1;
      tick();

      // Reset state
      check("reset.busy", RX_BUSY, 0);
      check("reset.done", RX_DONE, 0);
      check("reset.dout", BUS_DATA_OUT, 0);
      bus_read(0, d); check("version", d, 1);
      bus_read(2, d); check("reset.len_lo", d, 0);
      bus_read(7, d); check("reserved7", d, 0);
      bus_read(16 + MEM_SIZE, d); check("beyond_mem", d, 0);
      check_all("reset");

      // Basic capture, strobes 3 cycles apart
      set_len(16); set_conf(0); do_arm();
      check("basic.armed_busy", RX_BUSY, 1);
      send_byte(8'hA5, 0, 2); send_byte(8'h3C, 0, 2);
      check("basic.mem0_lit", m_mem[0], 8'hA5);
      check_all("basic");

      // External start: flagless bits are dropped
      set_len(8); set_conf(1); do_arm();
      for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0, 1);
      check("ext.still_armed", RX_BUSY, 1);
      send_byte(8'h81, 1, 0);
      check_all("ext");

      // Partial last byte
      set_len(11); set_conf(0); do_arm();
      send_byte(8'hFF, 0, 0);
      send_bit(1, 0, 0); send_bit(0, 0, 0);
      check("partial.done_before", RX_DONE, 0);
      send_bit(1, 0, 0);
      check("partial.done_after", RX_DONE, 1);
      check_all("partial");

      // Overflow: length larger than memory
      set_len(200); do_arm();
      for (int i = 0; i < 200; i++) send_bit(1'($urandom), 0, 0);
      check_all("overflow");

      // Re-arm from DONE clears the flags
      do_arm();
      check_all("rearm");

      // ARM during CAPTURE is ignored
      set_len(24);
      for (int i = 0; i < 4; i++) send_bit(1'($urandom), 0, 0);
      do_arm();
      for (int i = 0; i < 20; i++) send_bit(1'($urandom), 0, 0);
      check_all("arm_in_capture");

      // Soft reset coinciding with a bit strobe
      do_arm();
      for (int i = 0; i < 3; i++) send_bit(1'b1, 0, 0);
      BUS_ADD = 16'd0; BUS_DATA_IN = 8'h00; BUS_WR = 1'b1;
      CMD_DATA = 1'b1; CMD_BIT_EN = 1'b1;
      tick();
      BUS_WR = 1'b0; CMD_BIT_EN = 1'b0;
      model_soft_reset();
      check_all("softrst");
      bus_read(2, d); check("softrst.len_kept", d, 24);

      // Randomized captures
      for (int r = 0; r < 6; r++) begin
         set_len($urandom_range(0, 140));
         set_conf($urandom_range(0, 1));
         do_arm();
         for (int i = 0; i < 170 && !m_done; i++)
            send_bit(1'($urandom), ($urandom_range(0, 3) == 0), $urandom_range(0, 2));
         if (!m_done) send_bit(1'($urandom), 1'b1, 0);
         check_all($sformatf("rand%0d", r));
      end

      // Asynchronous reset mid-capture
      set_len(40); set_conf(0); do_arm();
      for (int i = 0; i < 5; i++) send_bit(1'($urandom), 0, 0);
      bus_read(1, d); check("prerst.status", d, 1);
      #2 BUS_RST_N = 1'b0;
      #1;
      check("asyncrst.busy", RX_BUSY, 0);
      check("asyncrst.done", RX_DONE, 0);
      check("asyncrst.dout", BUS_DATA_OUT, 0);
      tick();
      BUS_RST_N = 1'b1;
      tick();
      m_len = 0; m_conf = 0;
      model_soft_reset();
      for (int i = 0; i < MEM_SIZE; i++) m_valid[i] = 0;
      check_all("asyncrst");
      bus_read(2, d); check("asyncrst.len_lo", d, 0);
      bus_read(3, d); check("asyncrst.len_hi", d, 0);
      bus_read(6, d); check("asyncrst.conf", d, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Global watchdog
   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

endmodule
`default_nettype wire

// File: doc/cmd_rx_core.md
Name: cmd_rx_core

Overview:
- Receive-side counterpart of the command sequencer: deserializes the serial command stream (data bit + bit strobe + start flag) back into bytes and stores them in an internal byte memory that software reads over the basil register bus.
- Used on test/loopback boards and on emulated front-ends to check what the sequencer actually emitted.
- Sits behind a bus_to_ip instance, exactly like other *_core blocks.

Parameters:
- ABUSWIDTH, 16, width of BUS_ADD.
- MEM_SIZE, 2048, capture memory depth in bytes; power of two, 16..8192.
- VERSION, 1, value returned on read of offset 0.

Ports:
- BUS_CLK  in  1  single clock for bus, capture and memory.
- BUS_RST_N  in  1  asynchronous, active-low reset.
- BUS_ADD  in  ABUSWIDTH  IP-relative address.
- BUS_DATA_IN  in  8  write data.
- BUS_RD  in  1  read strobe.
- BUS_WR  in  1  write strobe.
- BUS_DATA_OUT  out  8  read data, registered.
- CMD_DATA  in  1  serial command bit, MSB-first per byte.
- CMD_BIT_EN  in  1  one-BUS_CLK strobe marking a valid CMD_DATA bit.
- CMD_START_FLAG  in  1  high together with the first bit of a sequence.
- RX_BUSY  out  1  high in ARMED or CAPTURE.
- RX_DONE  out  1  high in DONE.

Behaviour:
- Reset: all outputs 0; state IDLE; CAPTURE_LEN=0; CONF=0; BIT_CNT=0; flags cleared; memory contents undefined.
- Register map:
  - 0: R VERSION; any W is a soft reset (state, counters, flags, shift reg; CAPTURE_LEN/CONF kept).
  - 1: R {5'b0, OVERFLOW, DONE, BUSY}; W bit0=1 is ARM.
  - 2/3: RW CAPTURE_LEN[7:0]/[15:8], in bits; 0 means MEM_SIZE*8.
  - 4/5: R BIT_CNT[7:0]/[15:8].
  - 6: RW CONF, bit0 EXT_START_EN.
  - 7..15: R 0.
  - 16..16+MEM_SIZE-1: R capture memory; W ignored.
  - All other offsets: R 0.
- Read latency: BUS_DATA_OUT is valid on the cycle after BUS_RD and holds until the next read.
- States:
  - IDLE -ARM-> ARMED.
  - DONE -ARM-> ARMED; ARM clears BIT_CNT, DONE and OVERFLOW.
  - ARMED -> CAPTURE:
    - If EXT_START_EN=0, on the first CMD_BIT_EN.
    - If EXT_START_EN=1, on CMD_BIT_EN & CMD_START_FLAG. Bits without the flag are discarded.
    - The starting bit is captured.
  - CAPTURE: each CMD_BIT_EN shifts CMD_DATA into an 8-bit shift register and increments BIT_CNT.
  - Byte write: on the 8th bit of a byte, the byte is written to memory[BIT_CNT/8].
  - CAPTURE -> DONE in the same cycle the bit with BIT_CNT reaching the effective length is taken. Any partial byte is written left-aligned, zero-padded.
- ARM while ARMED or CAPTURE: ignored.
- Soft reset: takes priority over a simultaneous ARM or CMD_BIT_EN.
- CMD_START_FLAG during CAPTURE: ignored; it does not restart the capture.
- Overflow: if CAPTURE_LEN > MEM_SIZE*8, capture stops at MEM_SIZE*8 bits, sets OVERFLOW, and goes to DONE. The address never wraps.
- BIT_CNT saturates at the effective length.
- Memory read during CAPTURE returns the current content. No bus write/read conflict exists: the memory is single-write-port (capture) and single-read-port (bus).
- Reset mid-capture (async): immediate return to the reset values above.

Decomposition:
- Shared package cmd_rx_pkg holds:
  - register offset constants (REG_VERSION=0, REG_STATUS=1, REG_LEN=2, REG_CNT=4, REG_CONF=6, MEM_OFFSET=16);
  - state enum IDLE/ARMED/CAPTURE/DONE;
  - status bit indices.
- One sub-module: cmd_rx_mem, a simple dual-port byte RAM (sync write from capture, registered read for bus), so it infers block RAM.
- A wrapper cmd_rx (bus_to_ip + core) is built later and is not part of this spec.

Test Plan:
- Basic capture: CAPTURE_LEN=16, EXT_START_EN=0, ARM, then send bytes 0xA5 0x3C as strobes spaced 3 cycles apart -> DONE=1, BIT_CNT=16, mem[16]=0xA5, mem[17]=0x3C, RX_BUSY=0.
- External start: EXT_START_EN=1, ARM, send 5 bits 1 without flag, then 0x81 with flag on the first bit -> mem[16]=0x81, BIT_CNT=8.
- Partial byte: CAPTURE_LEN=11, stream 0xFF then bits 101 -> mem[16]=0xFF, mem[17]=0xA0, DONE after the 11th strobe.
- Overflow: MEM_SIZE=16, CAPTURE_LEN=200, stream 200 bits -> stop at 128 bits, OVERFLOW=1, BIT_CNT=128, mem[16+15] holds byte 15.
- Control corner cases:
  - ARM during CAPTURE -> no effect.
  - Soft reset (W offset 0) in the same cycle as CMD_BIT_EN -> IDLE, BIT_CNT=0.
  - Re-ARM from DONE -> flags cleared.
- Reset mid-capture: drop BUS_RST_N after 5 bits -> outputs 0 immediately, status reads 0x00, CAPTURE_LEN=0.
